// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage_if
// Brief    : Upstream, writeback and ALU-side signals of the operand stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int OPCODE_BIT_WIDTH = 4,
    parameter int DBITS            = 32,
    parameter int IMM_BITS         = 16,
    parameter int REG_ADDR_BITS    = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [OPCODE_BIT_WIDTH-1:0] in_aluOp;
    logic [REG_ADDR_BITS-1:0]    in_rsA;
    logic [REG_ADDR_BITS-1:0]    in_rsB;
    logic [DBITS-1:0]            in_valA;
    logic [DBITS-1:0]            in_valB;
    logic [IMM_BITS-1:0]         in_imm;
    logic                        in_useImm;
    logic                        wb_en;
    logic [REG_ADDR_BITS-1:0]    wb_addr;
    logic [DBITS-1:0]            wb_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [OPCODE_BIT_WIDTH-1:0] aluOp;
    logic [DBITS-1:0]            inA;
    logic [DBITS-1:0]            inB;

    modport master (
        output in_valid, in_aluOp, in_rsA, in_rsB, in_valA, in_valB, in_imm,
               in_useImm, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, aluOp, inA, inB
    );

    modport slave (
        input  in_valid, in_aluOp, in_rsA, in_rsB, in_valA, in_valB, in_imm,
               in_useImm, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, aluOp, inA, inB
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : Decode-to-execute operand register with immediate select,
//            writeback bypass and a 2-entry skid buffer.
//            Define ALU_OPERAND_STAGE_FLUSH_EN to add a synchronous flush input.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int OPCODE_BIT_WIDTH = 4,
    parameter int DBITS            = 32,
    parameter int IMM_BITS         = 16,
    parameter int REG_ADDR_BITS    = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
`ifdef ALU_OPERAND_STAGE_FLUSH_EN
    input  wire logic flush,
`endif
    alu_operand_stage_if.slave bus
);

    typedef struct packed {
        logic [OPCODE_BIT_WIDTH-1:0] op;
        logic [DBITS-1:0]            a;
        logic [DBITS-1:0]            b;
        logic [REG_ADDR_BITS-1:0]    rsA;
        logic [REG_ADDR_BITS-1:0]    rsB;
        logic                        useImm;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_outValid;
    logic       r_inReady;
    entry_t     r_main;
    entry_t     r_skid;

    logic       w_accept;
    logic       w_consume;
    logic       w_flush;
    logic       w_wbHit;
    logic [DBITS-1:0] w_extImm;
    entry_t     w_newEntry;
    entry_t     w_mainHeld;
    entry_t     w_skidHeld;

`ifdef ALU_OPERAND_STAGE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    generate
        if (IMM_BITS < DBITS) begin : g_signExt
            assign w_extImm = {{(DBITS-IMM_BITS){bus.in_imm[IMM_BITS-1]}}, bus.in_imm};
        end else begin : g_noExt
            assign w_extImm = bus.in_imm;
        end
    endgenerate

    assign w_accept  = bus.in_valid & r_inReady;
    assign w_consume = r_outValid & bus.out_ready;
    // Register 0 is hardwired zero, so a writeback to it never forwards.
    assign w_wbHit   = bus.wb_en & (bus.wb_addr != '0);

    // Writes that land on a held operand refresh it in place.
    function automatic entry_t heldBypass(input entry_t e, input logic hit,
                                          input logic [REG_ADDR_BITS-1:0] addr,
                                          input logic [DBITS-1:0] data);
        entry_t r;
        r = e;
        if (hit && (e.rsA == addr))
            r.a = data;
        if (hit && !e.useImm && (e.rsB == addr))
            r.b = data;
        return r;
    endfunction

    always_comb begin
        w_newEntry        = '0;
        w_newEntry.op     = bus.in_aluOp;
        w_newEntry.rsA    = bus.in_rsA;
        w_newEntry.rsB    = bus.in_rsB;
        w_newEntry.useImm = bus.in_useImm;
        w_newEntry.a      = (w_wbHit && (bus.wb_addr == bus.in_rsA)) ? bus.wb_data : bus.in_valA;
        if (bus.in_useImm)
            w_newEntry.b = w_extImm;
        else if (w_wbHit && (bus.wb_addr == bus.in_rsB))
            w_newEntry.b = bus.wb_data;
        else
            w_newEntry.b = bus.in_valB;
    end

    assign w_mainHeld = heldBypass(r_main, w_wbHit, bus.wb_addr, bus.wb_data);
    assign w_skidHeld = heldBypass(r_skid, w_wbHit, bus.wb_addr, bus.wb_data);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else if (w_flush) begin
            r_state    <= ST_EMPTY;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main     <= w_newEntry;
                        r_state    <= ST_ONE;
                        r_outValid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_consume) begin
                        r_skid    <= w_newEntry;
                        r_main    <= w_mainHeld;
                        r_state   <= ST_FULL;
                        r_inReady <= 1'b0;
                    end else if (w_accept && w_consume) begin
                        r_main <= w_newEntry;
                    end else if (w_consume) begin
                        r_state    <= ST_EMPTY;
                        r_outValid <= 1'b0;
                    end else begin
                        r_main <= w_mainHeld;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        // Skid promotes with any writeback landing this cycle applied.
                        r_main    <= w_skidHeld;
                        r_state   <= ST_ONE;
                        r_inReady <= 1'b1;
                    end else begin
                        r_main <= w_mainHeld;
                        r_skid <= w_skidHeld;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.aluOp     = r_main.op;
    assign bus.inA       = r_main.a;
    assign bus.inB       = r_main.b;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Directed self-checking bench for alu_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic clk;
    logic reset_n;
`ifdef ALU_OPERAND_STAGE_FLUSH_EN
    logic flush;
`endif
    int   nChecks;
    int   nFails;

    alu_operand_stage_if #(.OPCODE_BIT_WIDTH(4), .DBITS(32), .IMM_BITS(16), .REG_ADDR_BITS(4)) bus ();

    alu_operand_stage #(.OPCODE_BIT_WIDTH(4), .DBITS(32), .IMM_BITS(16), .REG_ADDR_BITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef ALU_OPERAND_STAGE_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus.in_valid  = 1'b0;
        bus.in_aluOp  = '0;
        bus.in_rsA    = '0;
        bus.in_rsB    = '0;
        bus.in_valA   = '0;
        bus.in_valB   = '0;
        bus.in_imm    = '0;
        bus.in_useImm = 1'b0;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
    endtask

    task automatic offer(input logic [3:0] op, input logic [3:0] rsA, input logic [3:0] rsB,
                         input logic [31:0] valA, input logic [31:0] valB,
                         input logic [15:0] imm, input logic useImm);
        bus.in_valid  = 1'b1;
        bus.in_aluOp  = op;
        bus.in_rsA    = rsA;
        bus.in_rsB    = rsB;
        bus.in_valA   = valA;
        bus.in_valB   = valB;
        bus.in_imm    = imm;
        bus.in_useImm = useImm;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        clearIn();
        repeat (2) tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL reset_outValid: got %0h expected 0", bus.out_valid); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("FAIL reset_inReady: got %0h expected 1", bus.in_ready); end
        nChecks++; if (bus.aluOp !== 4'h0) begin nFails++; $display("FAIL reset_aluOp: got %0h expected 0", bus.aluOp); end
        nChecks++; if (bus.inA !== 32'h0) begin nFails++; $display("FAIL reset_inA: got %0h expected 0", bus.inA); end
        nChecks++; if (bus.inB !== 32'h0) begin nFails++; $display("FAIL reset_inB: got %0h expected 0", bus.inB); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_immediate();
        bus.out_ready = 1'b1;
        offer(4'h3, 4'd1, 4'd2, 32'h11, 32'h55, 16'hFFFE, 1'b1);
        tick();
        nChecks++; if (bus.out_valid !== 1'b1) begin nFails++; $display("FAIL imm_latency: got %0h expected 1", bus.out_valid); end
        nChecks++; if (bus.inB !== 32'hFFFFFFFE) begin nFails++; $display("FAIL imm_negative: got %0h expected fffffffe", bus.inB); end
        nChecks++; if (bus.aluOp !== 4'h3) begin nFails++; $display("FAIL imm_aluOp: got %0h expected 3", bus.aluOp); end
        offer(4'h5, 4'd1, 4'd2, 32'h11, 32'h55, 16'h7FFF, 1'b1);
        tick();
        nChecks++; if (bus.inB !== 32'h00007FFF) begin nFails++; $display("FAIL imm_positive: got %0h expected 7fff", bus.inB); end
        nChecks++; if (bus.aluOp !== 4'h5) begin nFails++; $display("FAIL imm_aluOp2: got %0h expected 5", bus.aluOp); end
        clearIn();
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL imm_drain: got %0h expected 0", bus.out_valid); end
    endtask

    task automatic test_accept_bypass();
        bus.out_ready = 1'b1;
        offer(4'h1, 4'd3, 4'd4, 32'd5, 32'd6, 16'h0, 1'b0);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'd9;
        tick();
        nChecks++; if (bus.inA !== 32'd9) begin nFails++; $display("FAIL bypass_A: got %0h expected 9", bus.inA); end
        nChecks++; if (bus.inB !== 32'd6) begin nFails++; $display("FAIL bypass_B_nohit: got %0h expected 6", bus.inB); end
        offer(4'h1, 4'd0, 4'd0, 32'd5, 32'd7, 16'h0, 1'b0);
        bus.wb_addr = 4'd0;
        tick();
        nChecks++; if (bus.inA !== 32'd5) begin nFails++; $display("FAIL bypass_r0_A: got %0h expected 5", bus.inA); end
        nChecks++; if (bus.inB !== 32'd7) begin nFails++; $display("FAIL bypass_r0_B: got %0h expected 7", bus.inB); end
        offer(4'h2, 4'd1, 4'd3, 32'd5, 32'd6, 16'h0, 1'b0);
        bus.wb_addr = 4'd3;
        tick();
        nChecks++; if (bus.inA !== 32'd5) begin nFails++; $display("FAIL bypass_B_A: got %0h expected 5", bus.inA); end
        nChecks++; if (bus.inB !== 32'd9) begin nFails++; $display("FAIL bypass_B: got %0h expected 9", bus.inB); end
        offer(4'h2, 4'd1, 4'd3, 32'd5, 32'd6, 16'h0021, 1'b1);
        tick();
        nChecks++; if (bus.inB !== 32'h21) begin nFails++; $display("FAIL bypass_imm_B: got %0h expected 21", bus.inB); end
        clearIn();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        offer(4'h1, 4'd5, 4'd5, 32'hA1, 32'h0, 16'h0, 1'b0);
        tick();
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("FAIL bp_ready_after_X: got %0h expected 1", bus.in_ready); end
        offer(4'h2, 4'd5, 4'd5, 32'hA2, 32'h0, 16'h0, 1'b0);
        tick();
        nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("FAIL bp_ready_after_Y: got %0h expected 0", bus.in_ready); end
        nChecks++; if (bus.aluOp !== 4'h1) begin nFails++; $display("FAIL bp_hold_X: got %0h expected 1", bus.aluOp); end
        offer(4'h3, 4'd5, 4'd5, 32'hA3, 32'h0, 16'h0, 1'b0);
        tick();
        nChecks++; if (bus.inA !== 32'hA1) begin nFails++; $display("FAIL bp_stable_X: got %0h expected a1", bus.inA); end
        nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("FAIL bp_full_ready: got %0h expected 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.inA !== 32'hA2) begin nFails++; $display("FAIL bp_order_Y: got %0h expected a2", bus.inA); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("FAIL bp_ready_resume: got %0h expected 1", bus.in_ready); end
        tick();
        nChecks++; if (bus.inA !== 32'hA3) begin nFails++; $display("FAIL bp_order_Z: got %0h expected a3", bus.inA); end
        nChecks++; if (bus.aluOp !== 4'h3) begin nFails++; $display("FAIL bp_op_Z: got %0h expected 3", bus.aluOp); end
        clearIn();
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL bp_drain: got %0h expected 0", bus.out_valid); end
    endtask

    task automatic test_held_update();
        bus.out_ready = 1'b0;
        offer(4'h4, 4'd1, 4'd7, 32'h0, 32'hAAAA, 16'h0, 1'b0);
        tick();
        clearIn();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h1234;
        tick();
        nChecks++; if (bus.inB !== 32'h1234) begin nFails++; $display("FAIL held_B: got %0h expected 1234", bus.inB); end
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        offer(4'h4, 4'd1, 4'd7, 32'h0, 32'hAAAA, 16'h0010, 1'b1);
        tick();
        clearIn();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h1234;
        tick();
        nChecks++; if (bus.inB !== 32'h10) begin nFails++; $display("FAIL held_imm_B: got %0h expected 10", bus.inB); end
        bus.wb_addr = 4'd0; bus.wb_data = 32'h99;
        tick();
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        // Register 0 held: write to r0 must not disturb the stored operand.
        bus.out_ready = 1'b0;
        offer(4'h6, 4'd0, 4'd0, 32'h33, 32'h44, 16'h0, 1'b0);
        tick();
        clearIn();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 32'h99;
        tick();
        nChecks++; if (bus.inA !== 32'h33) begin nFails++; $display("FAIL held_r0_A: got %0h expected 33", bus.inA); end
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        // Skid-entry update, then promotion to main.
        bus.out_ready = 1'b0;
        offer(4'h7, 4'd2, 4'd0, 32'h20, 32'h0, 16'h0, 1'b0);
        tick();
        offer(4'h8, 4'd6, 4'd0, 32'h60, 32'h0, 16'h0, 1'b0);
        tick();
        clearIn();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd6; bus.wb_data = 32'h66;
        tick();
        nChecks++; if (bus.inA !== 32'h20) begin nFails++; $display("FAIL held_main_untouched: got %0h expected 20", bus.inA); end
        bus.wb_en = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.inA !== 32'h66) begin nFails++; $display("FAIL held_skid_A: got %0h expected 66", bus.inA); end
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL held_drain: got %0h expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        offer(4'hA, 4'd1, 4'd2, 32'h10, 32'h20, 16'h0, 1'b0);
        tick();
        offer(4'hB, 4'd1, 4'd2, 32'h30, 32'h40, 16'h0, 1'b0);
        tick();
        clearIn();
        nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("FAIL rst_mid_full: got %0h expected 0", bus.in_ready); end
        #2 reset_n = 1'b0;
        #1;
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL rst_mid_outValid: got %0h expected 0", bus.out_valid); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("FAIL rst_mid_inReady: got %0h expected 1", bus.in_ready); end
        nChecks++; if (bus.aluOp !== 4'h0) begin nFails++; $display("FAIL rst_mid_aluOp: got %0h expected 0", bus.aluOp); end
        nChecks++; if (bus.inA !== 32'h0) begin nFails++; $display("FAIL rst_mid_inA: got %0h expected 0", bus.inA); end
        nChecks++; if (bus.inB !== 32'h0) begin nFails++; $display("FAIL rst_mid_inB: got %0h expected 0", bus.inB); end
        tick();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        offer(4'h9, 4'd1, 4'd2, 32'h77, 32'h88, 16'h0, 1'b0);
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL rst_release_early: got %0h expected 0", bus.out_valid); end
        tick();
        nChecks++; if (bus.out_valid !== 1'b1) begin nFails++; $display("FAIL rst_release_valid: got %0h expected 1", bus.out_valid); end
        nChecks++; if (bus.inA !== 32'h77) begin nFails++; $display("FAIL rst_release_inA: got %0h expected 77", bus.inA); end
        clearIn();
        tick();
    endtask

`ifdef ALU_OPERAND_STAGE_FLUSH_EN
    task automatic test_flush();
        bus.out_ready = 1'b0;
        offer(4'h1, 4'd1, 4'd1, 32'h1, 32'h1, 16'h0, 1'b0);
        tick();
        offer(4'h2, 4'd1, 4'd1, 32'h2, 32'h2, 16'h0, 1'b0);
        tick();
        offer(4'h3, 4'd1, 4'd1, 32'h3, 32'h3, 16'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL flush_outValid: got %0h expected 0", bus.out_valid); end
        nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("FAIL flush_inReady: got %0h expected 1", bus.in_ready); end
        clearIn();
        bus.out_ready = 1'b1;
        tick();
        nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("FAIL flush_dropped: got %0h expected 0", bus.out_valid); end
    endtask
`endif

    initial begin
        nChecks = 0;
        nFails  = 0;
`ifdef ALU_OPERAND_STAGE_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_immediate();
        test_accept_bypass();
        test_back_to_back();
        test_held_update();
        test_reset_midstream();
`ifdef ALU_OPERAND_STAGE_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
